// File: rtl/mul_sequencer.sv
// mul_sequencer: microcode sequencer that drives the 12-bit opcode input of
// the control datapath with a fixed shift-and-add multiply program.
// On a start pulse in IDLE it loads X->B and Y->C, then runs ITER iterations
// of shift / accumulate / write-back. On the final iteration it can insert a
// two's-complement of B when C's sign bit is set.
// Every program step holds its opcode for STEP_CYCLES clocks. All outputs are
// registered.

module mul_sequencer #(
  parameter int STEP_CYCLES = 4,  // clocks per opcode, >= 2
  parameter int ITER        = 5   // multiply iterations, 1..7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        c_msb,
  output logic [11:0] opcode,
  output logic        busy,
  output logic        done,
  output logic [2:0]  iter
);

  // Width of the per-step clock counter.
  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [2:0]       ITER_LAST = 3'(ITER - 1);

  // Opcode constants understood by the control datapath.
  localparam logic [11:0] IDLE_OP    = 12'h009;
  localparam logic [11:0] LD_XB      = 12'h00B;
  localparam logic [11:0] LD_YC      = 12'h00C;
  localparam logic [11:0] AND_LSB    = 12'h205;
  localparam logic [11:0] SHL_B      = 12'h213;
  localparam logic [11:0] SHR_C      = 12'h02A;
  localparam logic [11:0] MOV_BO_B   = 12'h84B;
  localparam logic [11:0] NEG_B      = 12'h218;
  localparam logic [11:0] MOV_AO_A   = 12'h809;
  localparam logic [11:0] AND_LSB_CO = 12'h385;
  localparam logic [11:0] MOV_AO_C   = 12'h42C;
  localparam logic [11:0] ADD        = 12'h000;
  localparam logic [11:0] MOV_CO_C   = 12'h48C;

  // Program states, in issue order.
  typedef enum logic [3:0] {
    IDLE,
    S_LDB,
    S_LDC,
    S_AND0,
    S_SHL,
    S_SHR,
    S_PRENEG,
    S_NEG,
    S_MOVA,
    S_MOVB,
    S_ANDC,
    S_MOVC,
    S_ADD,
    S_MOVCO,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic             step_end;
  state_t           nxt;

  // Opcode that goes with each state.
  function automatic logic [11:0] op_of(input state_t s);
    // NOTE: the default arm makes the decode total, so a case like this never
    // infers a latch when it is reused from combinational code.
    case (s)
      S_LDB:    op_of = LD_XB;
      S_LDC:    op_of = LD_YC;
      S_AND0:   op_of = AND_LSB;
      S_SHL:    op_of = SHL_B;
      S_SHR:    op_of = SHR_C;
      S_PRENEG: op_of = MOV_BO_B;
      S_NEG:    op_of = NEG_B;
      S_MOVA:   op_of = MOV_AO_A;
      S_MOVB:   op_of = MOV_BO_B;
      S_ANDC:   op_of = AND_LSB_CO;
      S_MOVC:   op_of = MOV_AO_C;
      S_ADD:    op_of = ADD;
      S_MOVCO:  op_of = MOV_CO_C;
      default:  op_of = IDLE_OP;
    endcase
  endfunction

  // True for every state that is part of the program proper.
  function automatic logic in_prog(input state_t s);
    in_prog = (s != IDLE) && (s != DONE);
  endfunction

  // Successor state. It is used only when the current step ends.
  function automatic state_t next_of(input state_t s, input logic start_i,
                                     input logic last_i, input logic msb_i);
    case (s)
      IDLE:     next_of = start_i ? S_LDB : IDLE;
      S_LDB:    next_of = S_LDC;
      S_LDC:    next_of = S_AND0;
      S_AND0:   next_of = S_SHL;
      S_SHL:    next_of = S_SHR;
      // The final iteration negates B when C is negative. c_msb is looked at
      // only on this one cycle.
      S_SHR:    next_of = (last_i && msb_i) ? S_PRENEG : S_MOVA;
      S_PRENEG: next_of = S_NEG;
      S_NEG:    next_of = S_MOVA;
      S_MOVA:   next_of = S_MOVB;
      S_MOVB:   next_of = S_ANDC;
      S_ANDC:   next_of = S_MOVC;
      S_MOVC:   next_of = S_ADD;
      S_ADD:    next_of = S_MOVCO;
      S_MOVCO:  next_of = last_i ? DONE : S_SHL;
      default:  next_of = IDLE;
    endcase
  endfunction

  assign last_iter = (iter == ITER_LAST);
  assign nxt       = next_of(state, start, last_iter, c_msb);

  // The current state ends its step in this cycle. IDLE ends only on start,
  // DONE always lasts one cycle, and program states last STEP_CYCLES clocks.
  assign step_end = (state == IDLE) ? start :
                    (state == DONE) ? 1'b1 :
                    (cnt == CNT_LAST);

  // Sequencer FSM: state, step counter, iteration index and registered outputs.
  // NOTE: all state is assigned with <= so that every register samples the
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      iter   <= '0;
      opcode <= IDLE_OP;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (step_end) begin
      state  <= nxt;
      cnt    <= '0;
      opcode <= op_of(nxt);
      busy   <= in_prog(nxt);
      done   <= (nxt == DONE);
      if (state == IDLE) begin
        iter <= '0;
      end else if (state == S_MOVCO && !last_iter) begin
        iter <= iter + 3'd1;
      end
    end else if (in_prog(state)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer. Directed steps with hand-derived opcode
// programs. Instance dut runs with the default parameters (4 clocks per step,
// 5 iterations). Instance dut2 uses 2 clocks per step and 1 iteration.
// Outputs are sampled on the falling clock edge, and inputs are also driven
// there.

module tb_mul_sequencer;

  localparam int P_STEP  = 4;
  localparam int P_ITER  = 5;
  localparam int P2_STEP = 2;
  localparam int P2_ITER = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        c_msb;
  logic [11:0] opcode;
  logic        busy;
  logic        done;
  logic [2:0]  iter;

  logic        start2;
  logic        c_msb2;
  logic [11:0] opcode2;
  logic        busy2;
  logic        done2;
  logic [2:0]  iter2;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected program, one entry per step: the opcode and its iteration index.
  logic [11:0] e_op[$];
  int          e_it[$];

  mul_sequencer #(.STEP_CYCLES(P_STEP), .ITER(P_ITER)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .c_msb  (c_msb),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .iter   (iter)
  );

  mul_sequencer #(.STEP_CYCLES(P2_STEP), .ITER(P2_ITER)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .c_msb  (c_msb2),
    .opcode (opcode2),
    .busy   (busy2),
    .done   (done2),
    .iter   (iter2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Builds the expected program from the published opcode table.
  task automatic build(input int iters, input bit neg);
    e_op.delete();
    e_it.delete();
    e_op.push_back(12'h00B); e_it.push_back(0);
    e_op.push_back(12'h00C); e_it.push_back(0);
    e_op.push_back(12'h205); e_it.push_back(0);
    for (int i = 0; i < iters; i++) begin
      e_op.push_back(12'h213); e_it.push_back(i);
      e_op.push_back(12'h02A); e_it.push_back(i);
      if (neg && i == iters - 1) begin
        e_op.push_back(12'h84B); e_it.push_back(i);
        e_op.push_back(12'h218); e_it.push_back(i);
      end
      e_op.push_back(12'h809); e_it.push_back(i);
      e_op.push_back(12'h84B); e_it.push_back(i);
      e_op.push_back(12'h385); e_it.push_back(i);
      e_op.push_back(12'h42C); e_it.push_back(i);
      e_op.push_back(12'h000); e_it.push_back(i);
      e_op.push_back(12'h48C); e_it.push_back(i);
    end
  endtask

  // One program run on dut, entered at a falling edge while dut is idle.
  // c_mode: 0 = c_msb low, 1 = c_msb high, 2 = c_msb high before the last
  // iteration only. restart_at pulses start at that run clock. abort_at
  // asserts reset at that run clock.
  task automatic run1(input bit exp_neg, input int c_mode, input int restart_at,
                      input int abort_at);
    int cyc;
    int busy_cnt;
    int neg_seen;
    build(P_ITER, exp_neg);
    cyc      = 0;
    busy_cnt = 0;
    neg_seen = 0;
    start = 1'b1;
    c_msb = (c_mode == 1);
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < e_op.size(); s++) begin
      for (int k = 0; k < P_STEP; k++) begin
        if (cyc == abort_at) begin
          rst_n = 1'b0;
          #1;
          check("abort_opcode", opcode, 12'h009);
          check("abort_busy", busy, 1'b0);
          check("abort_iter", iter, 3'd0);
          check("abort_done", done, 1'b0);
          repeat (3) begin
            @(negedge clk);
            check("abort_hold_done", done, 1'b0);
            check("abort_hold_opcode", opcode, 12'h009);
          end
          rst_n = 1'b1;
          @(negedge clk);
          check("abort_idle_opcode", opcode, 12'h009);
          check("abort_idle_busy", busy, 1'b0);
          check("abort_idle_done", done, 1'b0);
          return;
        end
        check("run_opcode", opcode, e_op[s]);
        check("run_busy", busy, 1'b1);
        check("run_iter", iter, e_it[s]);
        check("run_done", done, 1'b0);
        if (busy === 1'b1) busy_cnt++;
        if (opcode === 12'h218) neg_seen++;
        case (c_mode)
          0:       c_msb = 1'b0;
          1:       c_msb = 1'b1;
          default: c_msb = (e_it[s] < P_ITER - 1);
        endcase
        start = (cyc == restart_at);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_opcode", opcode, 12'h009);
    check("done_iter", iter, P_ITER - 1);
    check("busy_length", busy_cnt, (3 + 8 * P_ITER + 2 * exp_neg) * P_STEP);
    check("neg_issued", neg_seen, exp_neg ? P_STEP : 0);
    @(negedge clk);
    check("after_done", done, 1'b0);
    check("after_busy", busy, 1'b0);
    check("after_opcode", opcode, 12'h009);
    check("after_iter", iter, P_ITER - 1);
  endtask

  // One run on dut2, entered at the falling edge inside its first program
  // cycle. The run ends with the DONE cycle checked.
  task automatic run2(input bit drop_start);
    int busy_cnt;
    build(P2_ITER, 1'b1);
    busy_cnt = 0;
    for (int s = 0; s < e_op.size(); s++) begin
      for (int k = 0; k < P2_STEP; k++) begin
        check("sweep_opcode", opcode2, e_op[s]);
        check("sweep_busy", busy2, 1'b1);
        check("sweep_iter", iter2, e_it[s]);
        check("sweep_done", done2, 1'b0);
        if (busy2 === 1'b1) busy_cnt++;
        @(negedge clk);
      end
    end
    check("sweep_busy_length", busy_cnt, 26);
    check("sweep_done_pulse", done2, 1'b1);
    check("sweep_done_busy", busy2, 1'b0);
    check("sweep_done_opcode", opcode2, 12'h009);
    if (drop_start) start2 = 1'b0;
    @(negedge clk);
    check("sweep_idle_opcode", opcode2, 12'h009);
    check("sweep_idle_busy", busy2, 1'b0);
    check("sweep_idle_done", done2, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    c_msb  = 1'b0;
    start2 = 1'b0;
    c_msb2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_opcode", opcode, 12'h009);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_iter", iter, 3'd0);
    check("reset_opcode2", opcode2, 12'h009);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low for 50 clocks.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_opcode", opcode, 12'h009);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_iter", iter, 3'd0);
    end

    // Positive run, with negation and with c_msb high only on earlier iterations.
    run1(1'b0, 0, -1, -1);
    run1(1'b1, 1, -1, -1);
    run1(1'b0, 2, -1, -1);
    // A second start at clock 50 is ignored.
    run1(1'b0, 0, 50, -1);
    // Reset at clock 90 aborts the run, and the next start runs cleanly.
    run1(1'b0, 0, -1, 90);
    run1(1'b0, 0, -1, -1);

    // Parameter sweep on dut2: start held high gives back-to-back runs.
    start2 = 1'b1;
    c_msb2 = 1'b1;
    @(negedge clk);
    run2(1'b0);
    run2(1'b1);
    check("sweep_final_idle", busy2, 1'b0);
    check("sweep_final_opcode", opcode2, 12'h009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
